stream_demux: RTL

//   Registered 1-to-CHANNELS stream demultiplexer with valid/ready handshake, global enable,

---
 rtl/stream_demux_pkg.sv | 21 ++
 rtl/stream_demux_if.sv | 30 +++
 rtl/stream_demux_onehot.sv | 33 +++
 rtl/stream_demux.sv | 64 ++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer family: default sizes and a
// constant-foldable ceiling-log2 used to size channel select fields.
package stream_demux_pkg;

    localparam int DEF_WIDTH    = 1;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_CNT_W    = 8;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Producer-to-consumers stream bundle: one input word with routing info, one
// shared output word with a valid/ready pair per channel.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
);
    localparam int SEL_W = clog2(CHANNELS);

    logic [WIDTH-1:0]    in_data;
    logic [SEL_W-1:0]    in_sel;
    logic                in_bcast;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    out_data;
    logic [CHANNELS-1:0] out_valid;
    logic [CHANNELS-1:0] out_ready;

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/stream_demux_onehot.sv
// Combinational route decoder: select index plus broadcast flag to a channel
// mask, flagging selects that name a channel that does not exist.
module demux_onehot
    import stream_demux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = clog2(CHANNELS)
) (
    input  logic [SEL_W-1:0]    sel,
    input  logic                bcast,
    output logic [CHANNELS-1:0] mask,
    output logic                out_of_range
);

    // Broadcast wins over the select; a non-power-of-two channel count leaves
    // select codes with no channel, which produce an empty mask.
    always_comb begin
        mask         = '0;
        out_of_range = 1'b0;
        if (bcast) begin
            mask = '1;
        end else if (32'(sel) >= CHANNELS) begin
            out_of_range = 1'b1;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (32'(sel) == i) begin
                    mask[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-CHANNELS stream demux with per-channel handshake, broadcast,
// global enable and a saturating count of words dropped for a bad select.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    stream_demux_if.slave    bus,
    output logic [CNT_W-1:0] drop_count
);

    localparam int SEL_W = clog2(CHANNELS);

    logic [WIDTH-1:0]    data_q;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] route_mask;
    logic                out_of_range;
    logic                draining;
    logic                accept;

    demux_onehot #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_route (
        .sel          (bus.in_sel),
        .bcast        (bus.in_bcast),
        .mask         (route_mask),
        .out_of_range (out_of_range)
    );

    // The register may refill in the cycle its last pending channel completes.
    assign draining     = (pending & ~bus.out_ready) == '0;
    assign bus.in_ready = en && !rst && draining;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_data  = data_q;
    assign bus.out_valid = pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            pending    <= '0;
            drop_count <= '0;
        end else begin
            pending <= pending & ~bus.out_ready;
            if (accept) begin
                if (out_of_range) begin
                    if (drop_count != {CNT_W{1'b1}}) begin
                        drop_count <= drop_count + 1'b1;
                    end
                end else begin
                    data_q  <= bus.in_data;
                    pending <= route_mask;
                end
            end
        end
    end

endmodule
